// File: rtl/multi_pulse_counter_if.sv
// Host-side bundle for multi_pulse_counter: per-channel pulse inputs and controls,
// live/snapshot counts and status. Parameters must match the attached counter.
interface multi_pulse_counter_if #(
    parameter int CH_NUM    = 4,
    parameter int CNT_WIDTH = 8
);
    logic [CH_NUM-1:0]           i_cnt_en;
    logic [CH_NUM-1:0]           i_cnt_in;
    logic [CH_NUM-1:0]           i_cnt_clr;
    logic                        i_snap;
    logic [CH_NUM*CNT_WIDTH-1:0] o_cnt;
    logic [CH_NUM*CNT_WIDTH-1:0] o_snap;
    logic                        o_snap_vld;
    logic [CH_NUM-1:0]           o_ovf;
    logic [CH_NUM-1:0]           o_lvl;

    modport slave (
        input  i_cnt_en, i_cnt_in, i_cnt_clr, i_snap,
        output o_cnt, o_snap, o_snap_vld, o_ovf, o_lvl
    );

    modport master (
        output i_cnt_en, i_cnt_in, i_cnt_clr, i_snap,
        input  o_cnt, o_snap, o_snap_vld, o_ovf, o_lvl
    );
endinterface

// File: rtl/multi_pulse_counter.sv
// Multi-channel debounced pulse counter: sync -> symmetric debounce -> rising-edge
// count (wrap or saturate, sticky overflow), plus an atomic all-channel snapshot.
module multi_pulse_counter #(
    parameter int CH_NUM     = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int DEB_CYCLES = 16,
    parameter int SATURATE   = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    multi_pulse_counter_if.slave  bus
);

    localparam int                    FILT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [FILT_W-1:0]     FILT_LAST = FILT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

    logic [CH_NUM-1:0]           sync1_q;
    logic [CH_NUM-1:0]           sync2_q;
    logic [CH_NUM-1:0]           lvl_q;
    logic [CH_NUM-1:0]           lvl_d;
    logic [CH_NUM-1:0]           rise;
    logic [FILT_W-1:0]           filt_q [CH_NUM];
    logic [FILT_W-1:0]           filt_d [CH_NUM];
    logic [CNT_WIDTH-1:0]        cnt_q  [CH_NUM];
    logic [CNT_WIDTH-1:0]        cnt_d  [CH_NUM];
    logic [CH_NUM-1:0]           ovf_q;
    logic [CH_NUM-1:0]           ovf_d;
    logic [CH_NUM*CNT_WIDTH-1:0] cnt_flat;
    logic [CH_NUM*CNT_WIDTH-1:0] snap_q;
    logic                        snap_vld_q;

    // Two-flop synchroniser; the raw inputs are asynchronous to i_clk.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.i_cnt_in;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a run of DEB_CYCLES disagreeing samples toggles the level.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        for (int k = 0; k < CH_NUM; k++) begin
            filt_d[k] = '0;
            lvl_d[k]  = lvl_q[k];
            rise[k]   = 1'b0;
            if (sync2_q[k] != lvl_q[k]) begin
                if (filt_q[k] == FILT_LAST) begin
                    lvl_d[k] = ~lvl_q[k];
                    rise[k]  = ~lvl_q[k];
                end else begin
                    filt_d[k] = filt_q[k] + 1'b1;
                end
            end
        end
    end

    // Counter next state: clear beats a coincident count event.
    always_comb begin
        for (int k = 0; k < CH_NUM; k++) begin
            cnt_d[k] = cnt_q[k];
            ovf_d[k] = ovf_q[k];
            if (bus.i_cnt_clr[k]) begin
                cnt_d[k] = '0;
                ovf_d[k] = 1'b0;
            end else if (rise[k] && bus.i_cnt_en[k]) begin
                if (cnt_q[k] == CNT_MAX) begin
                    cnt_d[k] = (SATURATE != 0) ? CNT_MAX : '0;
                    ovf_d[k] = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // NOTE: these per-channel arrays are plain flops, not RAM, so each entry is reset explicitly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lvl_q <= '0;
            ovf_q <= '0;
            for (int k = 0; k < CH_NUM; k++) begin
                filt_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            lvl_q <= lvl_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < CH_NUM; k++) begin
                filt_q[k] <= filt_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    always_comb begin
        cnt_flat = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            cnt_flat[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
        end
    end

    // Snapshot captures the registered counts, i.e. values before this edge's updates.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            snap_q     <= '0;
            snap_vld_q <= 1'b0;
        end else begin
            snap_vld_q <= bus.i_snap;
            if (bus.i_snap) begin
                snap_q <= cnt_flat;
            end
        end
    end

    assign bus.o_cnt      = cnt_flat;
    assign bus.o_snap     = snap_q;
    assign bus.o_snap_vld = snap_vld_q;
    assign bus.o_ovf      = ovf_q;
    assign bus.o_lvl      = lvl_q;

endmodule

// File: tb/tb_multi_pulse_counter.sv
// Scoreboard bench for multi_pulse_counter: a wrapping and a saturating instance share
// stimulus; each snapshot pulse is checked against expectations queued by the stimulus.
module tb_multi_pulse_counter;

    localparam int CH  = 4;
    localparam int CW  = 8;
    localparam int DEB = 16;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    logic [CH-1:0] cnt_en  = '1;
    logic [CH-1:0] cnt_in  = '0;
    logic [CH-1:0] cnt_clr = '0;
    logic          snap    = 1'b0;

    multi_pulse_counter_if #(.CH_NUM(CH), .CNT_WIDTH(CW)) bus_w ();
    multi_pulse_counter_if #(.CH_NUM(CH), .CNT_WIDTH(CW)) bus_s ();

    assign bus_w.i_cnt_en  = cnt_en;
    assign bus_w.i_cnt_in  = cnt_in;
    assign bus_w.i_cnt_clr = cnt_clr;
    assign bus_w.i_snap    = snap;
    assign bus_s.i_cnt_en  = cnt_en;
    assign bus_s.i_cnt_in  = cnt_in;
    assign bus_s.i_cnt_clr = cnt_clr;
    assign bus_s.i_snap    = snap;

    multi_pulse_counter #(.CH_NUM(CH), .CNT_WIDTH(CW), .DEB_CYCLES(DEB), .SATURATE(0)) dut_w (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus_w)
    );

    multi_pulse_counter #(.CH_NUM(CH), .CNT_WIDTH(CW), .DEB_CYCLES(DEB), .SATURATE(1)) dut_s (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus_s)
    );

    typedef struct {
        string       name;
        logic [31:0] snap;
        logic [31:0] cnt;
        logic [3:0]  ovf;
        logic [3:0]  lvl;
    } exp_t;

    exp_t q_w[$];
    exp_t q_s[$];
    exp_t mon_w;
    exp_t mon_s;
    int   n_cmp = 0;
    int   n_err = 0;

    // Hand-maintained expected state after the most recent edge
    logic [7:0] e_w [CH];
    logic [7:0] e_s [CH];
    logic [3:0] e_ovf_w = '0;
    logic [3:0] e_ovf_s = '0;
    logic [3:0] e_lvl   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cur_w();
        return {e_w[3], e_w[2], e_w[1], e_w[0]};
    endfunction

    function automatic logic [31:0] cur_s();
        return {e_s[3], e_s[2], e_s[1], e_s[0]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Queue the response to a snapshot taken on the next edge; e_* already hold post-edge values.
    task automatic expect_snap(input string name, input logic [31:0] pre_w, input logic [31:0] pre_s);
        exp_t it;
        it.name = {name, "_w"};
        it.snap = pre_w;
        it.cnt  = cur_w();
        it.ovf  = e_ovf_w;
        it.lvl  = e_lvl;
        q_w.push_back(it);
        it.name = {name, "_s"};
        it.snap = pre_s;
        it.cnt  = cur_s();
        it.ovf  = e_ovf_s;
        q_s.push_back(it);
    endtask

    task automatic snap_now(input string name);
        snap = 1'b1;
        expect_snap(name, cur_w(), cur_s());
        tick(1);
        snap = 1'b0;
        tick(1);
    endtask

    task automatic pulse(input int ch, input int hi, input int lo);
        cnt_in[ch] = 1'b1;
        tick(hi);
        cnt_in[ch] = 1'b0;
        tick(lo);
    endtask

    task automatic set_both(input int ch, input logic [7:0] v);
        e_w[ch] = v;
        e_s[ch] = v;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cnt_w"},  bus_w.o_cnt, 32'h0);
        check({tag, "_snap_w"}, bus_w.o_snap, 32'h0);
        check({tag, "_vld_w"},  32'(bus_w.o_snap_vld), 32'h0);
        check({tag, "_ovf_w"},  32'(bus_w.o_ovf), 32'h0);
        check({tag, "_lvl_w"},  32'(bus_w.o_lvl), 32'h0);
        check({tag, "_cnt_s"},  bus_s.o_cnt, 32'h0);
        check({tag, "_snap_s"}, bus_s.o_snap, 32'h0);
    endtask

    always @(negedge i_clk) begin
        if (bus_w.o_snap_vld === 1'b1) begin
            if (q_w.size() == 0) begin
                check("unexpected_vld_w", 32'h1, 32'h0);
            end else begin
                mon_w = q_w.pop_front();
                check({mon_w.name, "_snap"}, bus_w.o_snap, mon_w.snap);
                check({mon_w.name, "_cnt"},  bus_w.o_cnt,  mon_w.cnt);
                check({mon_w.name, "_ovf"},  32'(bus_w.o_ovf), 32'(mon_w.ovf));
                check({mon_w.name, "_lvl"},  32'(bus_w.o_lvl), 32'(mon_w.lvl));
            end
        end
    end

    always @(negedge i_clk) begin
        if (bus_s.o_snap_vld === 1'b1) begin
            if (q_s.size() == 0) begin
                check("unexpected_vld_s", 32'h1, 32'h0);
            end else begin
                mon_s = q_s.pop_front();
                check({mon_s.name, "_snap"}, bus_s.o_snap, mon_s.snap);
                check({mon_s.name, "_cnt"},  bus_s.o_cnt,  mon_s.cnt);
                check({mon_s.name, "_ovf"},  32'(bus_s.o_ovf), 32'(mon_s.ovf));
                check({mon_s.name, "_lvl"},  32'(bus_s.o_lvl), 32'(mon_s.lvl));
            end
        end
    end

    initial begin
        logic [31:0] pw;
        logic [31:0] ps;
        for (int k = 0; k < CH; k++) set_both(k, 8'd0);

        // Reset state
        tick(3);
        check_reset("rst");
        i_rst = 1'b0;
        snap_now("reset_state");

        // Ch0 latency: the next edge is edge 1; level and count change exactly at edge 18
        cnt_in[0] = 1'b1;
        tick(16);
        snap = 1'b1;
        expect_snap("ch0_edge17", cur_w(), cur_s());
        tick(1);
        pw = cur_w();
        ps = cur_s();
        set_both(0, 8'd1);
        e_lvl[0] = 1'b1;
        expect_snap("ch0_edge18", pw, ps);
        tick(1);
        snap = 1'b0;
        tick(2);
        cnt_in[0] = 1'b0;
        tick(20);
        e_lvl[0] = 1'b0;
        pulse(0, 20, 20);
        set_both(0, 8'd2);
        snap_now("ch0_second");

        // Ch1: 15-cycle glitch is rejected, 16-cycle pulse counts
        pulse(1, 15, 20);
        snap_now("ch1_glitch15");
        pulse(1, 16, 20);
        set_both(1, 8'd1);
        snap_now("ch1_pulse16");

        // Ch2: wrap vs saturate
        repeat (255) pulse(2, 20, 20);
        set_both(2, 8'd255);
        snap_now("ch2_255");
        pulse(2, 20, 20);
        e_w[2] = 8'd0;
        e_ovf_w[2] = 1'b1;
        e_ovf_s[2] = 1'b1;
        snap_now("ch2_256");
        repeat (44) pulse(2, 20, 20);
        e_w[2] = 8'd44;
        snap_now("ch2_300");

        // Clear with coincident snapshot: snapshot keeps the pre-clear value
        pw = cur_w();
        ps = cur_s();
        cnt_clr[2] = 1'b1;
        snap = 1'b1;
        set_both(2, 8'd0);
        e_ovf_w[2] = 1'b0;
        e_ovf_s[2] = 1'b0;
        expect_snap("ch2_clr_snap", pw, ps);
        tick(1);
        cnt_clr = '0;
        snap = 1'b0;
        tick(1);

        // Ch3: count event coincident with clear is lost
        repeat (2) pulse(3, 20, 20);
        set_both(3, 8'd2);
        cnt_in[3] = 1'b1;
        tick(17);
        pw = cur_w();
        ps = cur_s();
        cnt_clr[3] = 1'b1;
        snap = 1'b1;
        set_both(3, 8'd0);
        e_lvl[3] = 1'b1;
        expect_snap("ch3_clr_vs_count", pw, ps);
        tick(1);
        cnt_clr = '0;
        snap = 1'b0;
        tick(2);
        cnt_in[3] = 1'b0;
        tick(20);
        e_lvl[3] = 1'b0;
        snap_now("ch3_after_clr");
        repeat (5) pulse(3, 20, 20);
        set_both(3, 8'd5);
        snap_now("ch3_five");

        // Ch3: snapshot coincident with count event
        cnt_in[3] = 1'b1;
        tick(17);
        pw = cur_w();
        ps = cur_s();
        snap = 1'b1;
        set_both(3, 8'd6);
        e_lvl[3] = 1'b1;
        expect_snap("ch3_snap_vs_count", pw, ps);
        tick(1);
        snap = 1'b0;
        tick(2);
        cnt_in[3] = 1'b0;
        tick(20);
        e_lvl[3] = 1'b0;

        // Ch0: edge while disabled is dropped; raising enable mid-high does not count
        cnt_en[0] = 1'b0;
        cnt_in[0] = 1'b1;
        tick(20);
        e_lvl[0] = 1'b1;
        snap_now("en0_low_edge");
        cnt_en[0] = 1'b1;
        tick(10);
        snap_now("en0_raised_high");
        cnt_in[0] = 1'b0;
        tick(20);
        e_lvl[0] = 1'b0;
        snap_now("en0_after_low");
        pulse(0, 20, 20);
        set_both(0, 8'd3);
        snap_now("en0_new_pulse");

        // Reset mid-count with ch0 held high: recount after full latency
        cnt_in[0] = 1'b1;
        tick(10);
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        for (int k = 0; k < CH; k++) set_both(k, 8'd0);
        e_ovf_w = '0;
        e_ovf_s = '0;
        e_lvl   = '0;
        check_reset("rst_mid");
        tick(16);
        snap = 1'b1;
        expect_snap("rst_edge17", cur_w(), cur_s());
        tick(1);
        pw = cur_w();
        ps = cur_s();
        set_both(0, 8'd1);
        e_lvl[0] = 1'b1;
        expect_snap("rst_edge18", pw, ps);
        tick(1);
        snap = 1'b0;
        cnt_in[0] = 1'b0;

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20; i++) begin
            if (q_w.size() == 0 && q_s.size() == 0) break;
            tick(1);
        end
        if (q_w.size() != 0 || q_s.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d/%0d pending snapshots, expected 0/0", q_w.size(), q_s.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_pulse_counter.md
# multi_pulse_counter

Multi-channel debounced pulse counter, the parametrised successor of the single-channel debounced event counter. Each channel synchronises a raw external pulse input and qualifies it with a symmetric debounce filter. Each qualified rising edge increments a per-channel counter that either wraps or saturates, with a sticky overflow flag. A global snapshot captures all counters atomically so the host-side register block can read them coherently.

## Interface
- CH_NUM, 4, number of independent channels (>= 1)
- CNT_WIDTH, 8, width of each event counter (>= 2)
- DEB_CYCLES, 16, consecutive synchronised samples required to change the debounced level (>= 2); filter counter width is $clog2(DEB_CYCLES+1)
- SATURATE, 0, 0 = wrap max->0, 1 = hold at max
- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_cnt_en  in  CH_NUM  per-channel count enable, sampled on the cycle the debounced level rises
- i_cnt_in  in  CH_NUM  raw pulse inputs, asynchronous to i_clk
- i_cnt_clr  in  CH_NUM  per-channel synchronous clear of counter and overflow flag
- i_snap  in  1  snapshot request, single-cycle strobe
- o_cnt  out  CH_NUM*CNT_WIDTH  live counts; channel k at [k*CNT_WIDTH +: CNT_WIDTH]
- o_snap  out  CH_NUM*CNT_WIDTH  snapshot counts, same packing
- o_snap_vld  out  1  one-cycle pulse; o_snap was updated on the same edge
- o_ovf  out  CH_NUM  sticky overflow/saturation flag per channel
- o_lvl  out  CH_NUM  debounced level per channel

## Operation
- Per-channel path: 2-flop synchroniser (s1, s2) -> debounce filter -> rising-edge qualifier -> counter.
- Filter: the filter counter increments each cycle s2 != o_lvl and resets to 0 each cycle s2 == o_lvl. When it would reach DEB_CYCLES, o_lvl toggles and the filter counter resets to 0. Both directions are symmetric, so the channel re-arms only after a debounced low.
- Count event: o_lvl toggles 0->1 and i_cnt_en[k] = 1 in the same cycle. Falling toggles never count. An edge while i_cnt_en[k] = 0 is dropped permanently, and o_lvl still follows the input.
- Arithmetic: the counter is unsigned CNT_WIDTH.
  - At 2^CNT_WIDTH-1 with SATURATE=0: the next count event wraps the counter to 0 and sets o_ovf.
  - With SATURATE=1: the counter holds and o_ovf is set.
  - o_ovf stays set until i_cnt_clr or reset.
- Clear: i_cnt_clr[k] sets o_cnt channel k to 0 and o_ovf[k] to 0 on the next edge. Clear takes priority over a simultaneous count event, which is lost. The filter and o_lvl are unaffected by clear.
- Snapshot: i_snap = 1 copies all channels' o_cnt values, as they stand before that edge's updates, into o_snap. o_snap_vld pulses on the same edge. o_snap holds until the next i_snap.
- Simultaneous events:
  - snap + count: snapshot gets the old value, live counter gets the new value.
  - snap + clear: snapshot gets the pre-clear value.
- Reset: s1, s2, filter counters, o_lvl, o_cnt, o_snap, o_ovf and o_snap_vld all go to 0. Reset has priority over everything.
- Reset mid-pulse: o_lvl restarts at 0. An input still held high after reset is a new rising edge and is counted after the full latency.

## Timing
- Input path latency: edge 1 is the first edge that samples a clean high on i_cnt_in[k]. s2 is high after edge 2. o_lvl and o_cnt update on edge DEB_CYCLES+2 (edge 18 at default).
- Falling edge: o_lvl falls DEB_CYCLES+2 edges after the first low sample.
- Glitch rejection: a high (or low) run shorter than DEB_CYCLES cycles at s2 resets the filter and causes no toggle and no count.
- Minimum countable period: 2*DEB_CYCLES cycles (high and low phases each >= DEB_CYCLES).
- Clear latency: 1 edge. Snapshot latency: 1 edge, o_snap and o_snap_vld coincident.
- Channels are fully independent; count events on several channels in the same cycle all take effect.

## Test plan
- Reset, then hold i_cnt_in[0] = 1 from edge 1 with en = 1 -> o_lvl[0] and o_cnt ch0 = 1 exactly at edge 18; low for 16+ cycles, then high again -> ch0 = 2.
- 15-cycle high glitch on ch1 with en = 1 -> o_lvl[1] stays 0 and ch1 stays 0. A 16-cycle pulse -> ch1 = 1.
- Wrap and saturate:
  - SATURATE=0, 256 qualified pulses on ch2 -> ch2 = 0 and o_ovf[2] = 1.
  - SATURATE=1, 300 pulses -> ch2 = 255 and o_ovf[2] = 1.
  - i_cnt_clr[2] -> ch2 = 0 and o_ovf[2] = 0 after 1 edge.
- Count event on ch3 in the same cycle as i_cnt_clr[3] -> ch3 = 0 (event lost). Count event on ch3 with i_snap in that cycle (ch3 was 5) -> o_snap ch3 = 5, o_cnt ch3 = 6, o_snap_vld = 1 for one cycle.
- Rising edge while en[0] = 0, then en raised while input still high -> no count until a new low-then-high pulse.
- Assert i_rst for 1 cycle mid-count with input held high -> all outputs 0. The count reappears at 1, DEB_CYCLES+2 edges after reset release.
